// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one signed multiplier among NUM_REQ requesters,
// with operands registered before the multiplier and the product registered after it.
module Pipe_Line_Multiplier #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] p_o
);
    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;
    logic signed [PW-1:0] ah, al, bh, bl;
    // high halves carry the sign, low halves are unsigned magnitudes
    always_comb begin
        ah  = PW'($signed(a_i[WIDTH-1:H]));
        bh  = PW'($signed(b_i[WIDTH-1:H]));
        al  = PW'(a_i[H-1:0]);
        bl  = PW'(b_i[H-1:0]);
        p_o = ((ah * bh) <<< (2 * H)) + ((ah * bl + al * bh) <<< H) + al * bl;
    end
endmodule

module mult_share_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       res_valid,
    output logic [ID_W-1:0]            res_id,
    output logic [2*WIDTH-1:0]         res_product,
    output logic                       busy
);
    logic [ID_W-1:0]    last_q, last_d, grant_id, idx;
    logic               found, xfer;
    logic               s1_v_q, s2_v_q;
    logic [ID_W-1:0]    s1_id_q, s2_id_q;
    logic [WIDTH-1:0]   s1_a_q, s1_b_q;
    logic [2*WIDTH-1:0] s2_p_q, prod;

    // first valid requester after last, wrapping modulo NUM_REQ
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = idx;
            end
        end
    end

    assign xfer      = found & rst_n;
    assign req_ready = xfer ? (NUM_REQ'(1) << grant_id) : '0;
    assign last_d    = xfer ? grant_id : last_q;

    Pipe_Line_Multiplier #(.WIDTH(WIDTH)) u_mult (
        .a_i (s1_a_q),
        .b_i (s1_b_q),
        .p_o (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= ID_W'(NUM_REQ - 1);
            s1_v_q  <= 1'b0;
            s1_id_q <= '0;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            s2_v_q  <= 1'b0;
            s2_id_q <= '0;
            s2_p_q  <= '0;
        end else begin
            last_q <= last_d;
            s1_v_q <= xfer;
            if (xfer) begin
                s1_id_q <= grant_id;
                s1_a_q  <= req_a[grant_id*WIDTH +: WIDTH];
                s1_b_q  <= req_b[grant_id*WIDTH +: WIDTH];
            end
            s2_v_q  <= s1_v_q;
            s2_id_q <= s1_id_q;
            s2_p_q  <= prod;
        end
    end

    assign res_valid   = s2_v_q;
    assign res_id      = s2_id_q;
    assign res_product = s2_p_q;
    assign busy        = s1_v_q | s2_v_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed and randomised checks of grant order, latency and signed products.
module tb_mult_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [15:0] res_product;
    logic        busy;
    int checks = 0;
    int failures = 0;

    mult_share_arbiter #(.WIDTH(8), .NUM_REQ(4), .ID_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_product (res_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 4'h0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        step();
        step();
        checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL rst_res_id got=%0d exp=0", res_id); end
        checks++; if (res_product !== 16'h0000) begin failures++; $display("FAIL rst_product got=%h exp=0000", res_product); end
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        set_op(0, 8'h03, 8'hFB);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL basic_ready got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'h0;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_stage1 got v=%b busy=%b exp v=0 busy=1", res_valid, busy); end
        step();
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_product !== 16'hFFF1) begin
            failures++; $display("FAIL basic_result got v=%b id=%0d p=%h exp v=1 id=0 p=fff1", res_valid, res_id, res_product); end
        step();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL basic_single_pulse got=%b exp=0", res_valid); end
    endtask

    task automatic test_corners();
        logic [7:0]  ca [4] = '{8'h80, 8'h80, 8'h7F, 8'h00};
        logic [7:0]  cb [4] = '{8'h80, 8'h7F, 8'h7F, 8'hFF};
        logic [15:0] cp [4] = '{16'h4000, 16'hC080, 16'h3F01, 16'h0000};
        for (int n = 0; n < 4; n++) begin
            set_op(2, ca[n], cb[n]);
            req_valid = 4'b0100;
            #1;
            checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL corner%0d_ready got=%b exp=0100", n, req_ready); end
            step();
            req_valid = 4'h0;
            step();
            checks++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_product !== cp[n]) begin
                failures++; $display("FAIL corner%0d got v=%b id=%0d p=%h exp v=1 id=2 p=%h", n, res_valid, res_id, res_product, cp[n]); end
            step();
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] rp [4] = '{16'hFFC1, 16'hFF71, 16'h0080, 16'hFED4};
        do_reset();
        set_op(0, 8'hF9, 8'h09);
        set_op(1, 8'h0D, 8'hF5);
        set_op(2, 8'h80, 8'hFF);
        set_op(3, 8'h64, 8'hFD);
        for (int c = 0; c <= 10; c++) begin
            checks++; if (busy !== (c >= 1 && c <= 9)) begin failures++; $display("FAIL rr_busy c=%0d got=%b", c, busy); end
            if (c >= 2 && c < 10) begin
                checks++; if (res_valid !== 1'b1 || res_id !== 2'((c - 2) % 4) || res_product !== rp[(c - 2) % 4]) begin
                    failures++; $display("FAIL rr_result c=%0d got v=%b id=%0d p=%h exp v=1 id=%0d p=%h", c, res_valid, res_id, res_product, (c - 2) % 4, rp[(c - 2) % 4]); end
            end else begin
                checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rr_idle c=%0d got v=%b exp=0", c, res_valid); end
            end
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                checks++; if (req_ready !== (4'b0001 << (c % 4))) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, 4'b0001 << (c % 4)); end
            end
            step();
        end
    endtask

    task automatic test_skip_withdraw();
        logic [3:0] vin [8] = '{4'hA, 4'hA, 4'hA, 4'h8, 4'hA, 4'h0, 4'h0, 4'h0};
        logic [3:0] rdy [8] = '{4'h2, 4'h8, 4'h2, 4'h8, 4'h2, 4'h0, 4'h0, 4'h0};
        logic       ev  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] eid [8] = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd1, 2'd3, 2'd3, 2'd0};
        logic [15:0] ep;
        set_op(1, 8'h05, 8'hFA);
        set_op(3, 8'hF7, 8'hF7);
        for (int c = 0; c < 8; c++) begin
            ep = (eid[c] == 2'd1) ? 16'hFFE2 : 16'h0051;
            checks++; if (res_valid !== ev[c] || (ev[c] && (res_id !== eid[c] || res_product !== ep))) begin
                failures++; $display("FAIL skip_result c=%0d got v=%b id=%0d p=%h exp v=%b id=%0d p=%h", c, res_valid, res_id, res_product, ev[c], eid[c], ep); end
            req_valid = vin[c];
            #1;
            checks++; if (req_ready !== rdy[c]) begin failures++; $display("FAIL skip_grant c=%0d got=%b exp=%b", c, req_ready, rdy[c]); end
            if (c == 4) begin
                req_valid = 4'h8;
                #1;
                checks++; if (req_ready !== 4'h8) begin failures++; $display("FAIL withdraw_grant got=%b exp=1000", req_ready); end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        set_op(0, 8'h02, 8'h02);
        req_valid = 4'hF;
        step();
        step();
        checks++; if (res_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mid_pre got v=%b busy=%b exp v=1 busy=1", res_valid, busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_async got v=%b busy=%b exp 0 0", res_valid, busy); end
        checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL mid_ready got=%b exp=0000", req_ready); end
        req_valid = 4'h0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_stray c=%0d got v=%b busy=%b exp 0 0", c, res_valid, busy); end
        end
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_priority got=%b exp=0001", req_ready); end
        req_valid = 4'h0;
        step();
        step();
        step();
    endtask

    task automatic test_random();
        int mlast = 3;
        logic m1v = 1'b0, m2v = 1'b0;
        logic [1:0] m1id = '0, m2id = '0;
        logic signed [15:0] m1p = '0, m2p = '0;
        logic [3:0] exp_rdy;
        logic signed [7:0] ra, rb;
        int gid;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            checks++; if (res_valid !== m2v || (m2v && (res_id !== m2id || res_product !== m2p))) begin
                failures++; $display("FAIL rand_result c=%0d got v=%b id=%0d p=%h exp v=%b id=%0d p=%h", c, res_valid, res_id, res_product, m2v, m2id, m2p); end
            req_valid = 4'($urandom_range(0, 15));
            req_a = $urandom;
            req_b = $urandom;
            exp_rdy = 4'h0;
            gid = -1;
            for (int k = 1; k <= 4; k++) begin
                if (gid < 0 && req_valid[(mlast + k) % 4]) gid = (mlast + k) % 4;
            end
            if (gid >= 0) exp_rdy[gid] = 1'b1;
            #1;
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rand_grant c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
            m2v = m1v; m2id = m1id; m2p = m1p;
            m1v = (gid >= 0);
            if (gid >= 0) begin
                ra = req_a[gid*8 +: 8];
                rb = req_b[gid*8 +: 8];
                m1id = 2'(gid);
                m1p = ra * rb;
                mlast = gid;
            end
            step();
        end
        req_valid = 4'h0;
        step();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 4'h0;
        req_a = '0;
        req_b = '0;
        test_reset();
        test_basic();
        test_corners();
        test_round_robin();
        test_skip_withdraw();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
